// File: rtl/vpu_pkg.sv
// vpu_pkg: opcodes, vector width and FSM state shared by the vector execute stage.
package vpu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam int VEC_W = 256;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational single-lane ALU (op, a, b -> y).
// The signed slt comparator exists only when VEC_ALU_SLT_EN is defined.
module vec_lane_alu
    import vpu_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [2:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);
    logic [LANE_W-1:0] slt;
`ifdef VEC_ALU_SLT_EN
    assign slt = LANE_W'($signed(a) < $signed(b));
`else
    assign slt = '0;
`endif
    always_comb
        y = op == ALU_ADD ? a + b :
            op == ALU_SUB ? a - b :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_SLT ? slt   : '0;
endmodule

// File: rtl/vec_alu_exec.sv
// vec_alu_exec: multi-cycle vector execute stage, LANES_PER_BEAT lanes per beat behind valid/ready.
// Opcode 101 (slt) is enabled by defining VEC_ALU_SLT_EN.
module vec_alu_exec
    import vpu_pkg::*;
#(
    parameter int LANE_W         = 32,
    parameter int LANES          = 8,
    parameter int LANES_PER_BEAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [VEC_W-1:0] src_a,
    input  logic [VEC_W-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] result,
    output logic             zero
);
    localparam int BEATS = LANES / LANES_PER_BEAT;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;

    state_t                         state;
    logic [BW-1:0]                  beat;
    logic [2:0]                     op_q;
    logic [LANES-1:0][LANE_W-1:0]   a_q, b_q, res, res_next;
    logic [LW-1:0]                  lidx [LANES_PER_BEAT];
    logic [LANE_W-1:0]              y    [LANES_PER_BEAT];

    // Lane unit k handles lane beat*LANES_PER_BEAT+k of the latched operands.
    for (genvar k = 0; k < LANES_PER_BEAT; k++) begin : g_lane
        assign lidx[k] = LW'(int'(beat) * LANES_PER_BEAT + k);
        vec_lane_alu #(.LANE_W(LANE_W)) u_lane (
            .op(op_q),
            .a (a_q[lidx[k]]),
            .b (b_q[lidx[k]]),
            .y (y[k])
        );
    end

    always_comb begin
        res_next = res;
        for (int k = 0; k < LANES_PER_BEAT; k++) res_next[lidx[k]] = y[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            res   <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= src_a;
                    b_q   <= src_b;
                    op_q  <= ALUControl;
                    beat  <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    res  <= res_next;
                    beat <= beat + 1'b1;
                    if (beat == BW'(BEATS - 1)) begin
                        beat  <= '0;
                        zero  <= res_next == '0;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign result    = res;
endmodule

// File: tb/tb_vec_alu_exec.sv
// tb_vec_alu_exec: table-driven directed check of vec_alu_exec plus hold, input-toggle and abort sequences.
module tb_vec_alu_exec;
    import vpu_pkg::*;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, zero;
    logic [2:0]   ALUControl = '0;
    logic [255:0] src_a = '0, src_b = '0, result;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    vec_alu_exec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
    );

    typedef struct {
        logic [2:0]   op;
        logic [255:0] a, b, exp;
        logic         z;
        string        nm;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction: accept, count latency, check outputs, optionally hold and toggle inputs.
    task automatic run(input vec_t v, input int hold, input bit noise);
        int n;
        @(negedge clk);
        chk({v.nm, " in_ready_idle"}, 256'(in_ready), 256'(1));
        in_valid   = 1'b1;
        ALUControl = v.op;
        src_a      = v.a;
        src_b      = v.b;
        out_ready  = hold == 0;
        @(posedge clk); #1;
        in_valid = noise;
        n = 0;
        do begin
            if (noise) begin
                src_a      = {8{$urandom}};
                src_b      = ~src_b ^ {8{$urandom}};
                ALUControl = 3'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 20);
        chk({v.nm, " latency"}, 256'(n), 256'(4));
        chk({v.nm, " result"}, result, v.exp);
        chk({v.nm, " zero"}, 256'(zero), 256'(v.z));
        chk({v.nm, " in_ready_done"}, 256'(in_ready), 256'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({v.nm, " hold_valid"}, 256'(out_valid), 256'(1));
            chk({v.nm, " hold_result"}, result, v.exp);
            chk({v.nm, " hold_zero"}, 256'(zero), 256'(v.z));
            chk({v.nm, " hold_in_ready"}, 256'(in_ready), 256'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({v.nm, " release_in_ready"}, 256'(in_ready), 256'(1));
        chk({v.nm, " release_valid"}, 256'(out_valid), 256'(0));
    endtask

    initial begin
        logic [255:0] sa, sb;
        for (int i = 0; i < 8; i++) begin
            sa[i*32 +: 32] = 32'(i + 10);
            sb[i*32 +: 32] = 32'(i);
        end
        tv[0] = '{ALU_ADD, {8{32'hFFFFFFFF}}, {8{32'h1}}, '0, 1'b1, "add_wrap"};
        tv[1] = '{ALU_SUB, sa, sb, {8{32'd10}}, 1'b0, "sub_lanes"};
`ifdef VEC_ALU_SLT_EN
        tv[2] = '{ALU_SLT, {8{32'hFFFFFFFF}}, {8{32'h1}}, {8{32'h1}}, 1'b0, "slt_neg"};
`else
        tv[2] = '{ALU_SLT, {8{32'hFFFFFFFF}}, {8{32'h1}}, '0, 1'b1, "slt_neg"};
`endif
        tv[3] = '{ALU_AND, {8{32'hF0F0F0F0}}, {8{32'hFF00FF00}}, {8{32'hF000F000}}, 1'b0, "and"};
        tv[4] = '{ALU_OR, {8{32'hF0F0F0F0}}, {8{32'hFF00FF00}}, {8{32'hFFF0FFF0}}, 1'b0, "or"};
        tv[5] = '{3'b110, {8{32'hF0F0F0F0}}, {8{32'hFF00FF00}}, '0, 1'b1, "op110"};
        tv[6] = '{ALU_SLT, {8{32'h1}}, {8{32'hFFFFFFFF}}, '0, 1'b1, "slt_pos"};
        tv[7] = '{ALU_ADD, {8{32'h7FFFFFFF}}, {8{32'h1}}, {8{32'h80000000}}, 1'b0, "add_nocarry"};
        tv[8] = '{ALU_SUB, '0, {8{32'h1}}, {8{32'hFFFFFFFF}}, 1'b0, "sub_under"};
        tv[9] = '{3'b111, {8{32'h12345678}}, {8{32'h9ABCDEF0}}, '0, 1'b1, "op111"};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset out_valid", 256'(out_valid), 256'(0));
        chk("reset result", result, '0);
        chk("reset zero", 256'(zero), 256'(0));
        chk("reset in_ready", 256'(in_ready), 256'(1));

        for (int i = 0; i < 10; i++) run(tv[i], i == 1 ? 7 : 0, 1'b0);

        run(tv[3], 2, 1'b1);

        // Abort in beat 2, then a clean operation must show no residue.
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = ALU_OR;
        src_a      = {8{32'hF0F0F0F0}};
        src_b      = {8{32'hFF00FF00}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", 256'(out_valid), 256'(0));
        chk("abort result", result, '0);
        chk("abort zero", 256'(zero), 256'(0));
        chk("abort in_ready", 256'(in_ready), 256'(1));
        run(tv[1], 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vec_alu_exec.md
# vec_alu_exec

Multi-cycle vector execute stage of the processing element, sitting directly downstream of the ALU decoder. Accepts a 3-bit ALU control code and two 256-bit vector operands through a valid/ready handshake. Processes the operands lane-by-lane over several beats, then presents the 256-bit result and a zero flag to writeback and branch logic through a second valid/ready handshake.

## Interface
- LANE_W, 32: element width in bits.
- LANES, 8: lanes per vector; LANE_W*LANES = 256.
- LANES_PER_BEAT, 2: lanes computed per cycle; LANES must be divisible by it. BEATS = LANES/LANES_PER_BEAT.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept a bundle.
- ALUControl  in  3  operation code from the ALU decoder.
- src_a  in  256  vector operand A; lane i is bits [i*LANE_W +: LANE_W].
- src_b  in  256  vector operand B, with the same lane mapping.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  256  vector result.
- zero  out  1  high when result is all zeros.

## Operation
- Opcodes:
  - 000: add.
  - 001: sub (A−B).
  - 010: and.
  - 011: or.
  - 101: slt, signed per lane; lane result is 1 or 0, zero-extended.
  - 100, 110, 111: the lane result is 0.
- Add and sub wrap modulo 2^LANE_W. There is no carry between lanes.
- FSM has three states:
  - IDLE: in_ready=1. If in_valid, latch src_a, src_b and ALUControl, set beat=0, go to BUSY.
  - BUSY: compute lanes beat*LANES_PER_BEAT to beat*LANES_PER_BEAT+LANES_PER_BEAT−1 from the latched operands and write them into the result register. Increment beat. After beat BEATS−1, go to DONE.
  - DONE: out_valid=1, and result/zero are stable. If out_ready, go to IDLE.
- in_ready is high only in IDLE. Inputs are ignored outside IDLE.
- zero is registered on the transition into DONE. It reflects the full 256-bit result.
- Input changes after acceptance do not affect the operation in flight.
- Reset in any state aborts the operation and discards partial results.

## Timing
- Reset values: state IDLE, beat 0, out_valid 0, result 0, zero 0.
- in_ready is 1 in the first cycle after rst deasserts.
- If accepted at the edge ending cycle T:
  - BUSY in cycles T+1 to T+BEATS.
  - out_valid first high in cycle T+BEATS+1 (cycle T+5 with defaults).
- If out_ready is held high, out_valid lasts one cycle and in_ready returns in cycle T+BEATS+2. Minimum initiation interval is BEATS+2 cycles.
- If out_ready is held low, out_valid, result and zero hold indefinitely.
- in_valid and out_ready are sampled only in their own states. There is no combinational path from in_valid to out_valid.
- in_ready and out_valid are decoded from registered state only.

## Configuration
- VEC_ALU_SLT_EN:
  - Defined: opcode 101 performs per-lane signed set-less-than.
  - Undefined: opcode 101 behaves like the unused codes (lane result 0), and the signed comparator is not synthesized.
  - Handshake and latency are identical in both builds.

## Structure
- Shared package vpu_pkg holds:
  - Opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - VEC_W=256.
  - The FSM state typedef (IDLE/BUSY/DONE).
- One sub-module, vec_lane_alu: a combinational single-lane unit (op, a, b → y), parameterized by LANE_W.
  - Instantiated LANES_PER_BEAT times.
  - Fed by a beat-indexed mux over the latched operands.

## Test plan
- Reset release, then add with every A lane=0xFFFFFFFF and every B lane=1: result=0, zero=1, out_valid in cycle T+5.
- Sub with A lane i=i+10 and B lane i=i: every lane=10, zero=0. Hold out_ready low 7 cycles: outputs stable, in_ready=0 throughout.
- With VEC_ALU_SLT_EN, slt with A lanes=0xFFFFFFFF (−1) and B lanes=1: every lane=1. Without the macro: every lane=0, zero=1.
- And/or with A=0xF0F0…, B=0xFF00…: and=0xF000…, or=0xFFF0… patterns. Opcode 110 gives all-zero result with zero=1.
- Toggle src_a/src_b/ALUControl every cycle during BUSY: result matches the latched values. in_valid during BUSY/DONE is not accepted.
- Assert rst in BUSY beat 2: next cycle out_valid=0, result=0, in_ready=1. A new operation completes correctly with no residue from the aborted one.
